// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Owns every byte-level concern of RISC-V loads and stores between the
// execute stage and a word-addressed data memory. One request is accepted at
// a time. Accesses that cross a word boundary are split into two word beats
// (SPLIT_EN=1) or rejected with rsp_err (SPLIT_EN=0). Load results are sign-
// or zero-extended according to funct3.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   req_valid       request present
//   req_ready       high only in IDLE while rst is low
//   req_we          1 = store, 0 = load
//   req_funct3      lb/lh/lw/lbu/lhu or sb/sh/sw encoding
//   req_addr        byte address
//   req_wdata       store data, LSB-aligned
//   rsp_valid       one-cycle response pulse
//   rsp_rdata       extended load result (0 for stores and errors)
//   rsp_err         illegal funct3, or crossing access with SPLIT_EN=0
//   mem_wen/ren     memory write / read strobes
//   mem_addr        word-aligned byte address
//   mem_be          per-byte write enables
//   mem_data_i      write data to memory
//   mem_data_o      combinational read data from memory
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter logic SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_data_i,
    input  logic [31:0] mem_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_next;

    // Captured request fields
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        cross_q;
    logic        err_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    // Request decode
    logic [2:0] req_size;
    logic       req_illegal;
    logic       req_cross;
    logic       req_reject;
    logic       accept;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    always_comb begin
        if (req_we)
            req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

    // off + size tops out at 3 + 4 = 7, so a 3-bit sum cannot overflow.
    assign req_cross  = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
    assign req_reject = req_illegal || (req_cross && !SPLIT_EN);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cross_q  <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= 32'h0;
            hi_q     <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                cross_q  <= req_cross;
                err_q    <= req_reject;
                // The upper word stays zero unless a second beat refills it.
                hi_q     <= 32'h0;
            end
            if (state == ACC0 && !we_q)
                lo_q <= mem_data_o;
            if (state == ACC1 && !we_q)
                hi_q <= mem_data_o;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = req_reject ? RESP : ACC0;
            ACC0: state_next = cross_q ? ACC1 : RESP;
            ACC1: state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Store lanes: data and enables shifted into a two-word window.
    logic [3:0]  be_base;
    logic [7:0]  be8;
    logic [63:0] wide64;
    logic [31:0] word_addr;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    assign be8       = {4'b0000, be_base} << addr_q[1:0];
    assign wide64    = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign word_addr = {addr_q[31:2], 2'b00};

    // Memory drive is a pure decode of the state register and captured
    // fields, so it is stable for the whole cycle ahead of the negedge write.
    always_comb begin
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        mem_addr   = 32'h0;
        mem_be     = 4'b0000;
        mem_data_i = 32'h0;
        case (state)
            ACC0: begin
                mem_wen    = we_q;
                mem_ren    = !we_q;
                mem_addr   = word_addr;
                mem_be     = we_q ? be8[3:0] : 4'b1111;
                mem_data_i = we_q ? wide64[31:0] : 32'h0;
            end
            ACC1: begin
                mem_wen    = we_q;
                mem_ren    = !we_q;
                // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000.
                mem_addr   = word_addr + 32'd4;
                mem_be     = we_q ? be8[7:4] : 4'b1111;
                mem_data_i = we_q ? wide64[63:32] : 32'h0;
            end
            default: ;
        endcase
    end

    // Load lanes: shift the two-word window down by the byte offset.
    logic [31:0] lane;
    logic [31:0] load_result;

    assign lane = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  load_result = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_result = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_result = lane;
            3'b100:  load_result = {24'h0, lane[7:0]};
            3'b101:  load_result = {16'h0, lane[15:0]};
            default: load_result = 32'h0;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_rdata = ((state == RESP) && !we_q && !err_q) ? load_result : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Table-driven bench for load_store_unit. A word-addressed memory model with
// negedge byte-enabled writes sits behind the SPLIT_EN=1 instance; a second
// SPLIT_EN=0 instance with constant read data covers the reject path. Hand
// sequences cover reset-time outputs and reset between the beats of a split
// store.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;

    // SPLIT_EN=1 instance
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_addr, mem_data_i, mem_data_o;
    logic [3:0]  mem_be;

    // SPLIT_EN=0 instance
    logic        e_req_valid, e_req_ready, e_req_we;
    logic [2:0]  e_req_funct3;
    logic [31:0] e_req_addr, e_req_wdata;
    logic        e_rsp_valid, e_rsp_err;
    logic [31:0] e_rsp_rdata;
    logic        e_mem_wen, e_mem_ren;
    logic [31:0] e_mem_addr, e_mem_data_i;
    logic [3:0]  e_mem_be;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
    );

    load_store_unit #(.SPLIT_EN(1'b0)) e_dut (
        .clk(clk), .rst(rst),
        .req_valid(e_req_valid), .req_ready(e_req_ready), .req_we(e_req_we),
        .req_funct3(e_req_funct3), .req_addr(e_req_addr), .req_wdata(e_req_wdata),
        .rsp_valid(e_rsp_valid), .rsp_rdata(e_rsp_rdata), .rsp_err(e_rsp_err),
        .mem_wen(e_mem_wen), .mem_ren(e_mem_ren), .mem_addr(e_mem_addr),
        .mem_be(e_mem_be), .mem_data_i(e_mem_data_i), .mem_data_o(32'h12345678)
    );

    // Memory model: 1024 words indexed by addr[11:2], written on negedge.
    logic [31:0] mem [1024];

    assign mem_data_o = mem[mem_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h080] = 32'h11223344;   // word 0x200
        mem[10'h141] = 32'hFFFFFFFF;   // word 0x504
        mem[10'h3FF] = 32'h55667788;   // word 0xFFFFFFFC
        mem[10'h000] = 32'h99AABBCC;   // word 0x00000000
        forever begin
            @(negedge clk);
            if (mem_wen)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_data_i[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Beats observed during the last transaction
    int          nbeats;
    logic [31:0] beat_addr [4];
    logic [3:0]  beat_be   [4];
    logic [31:0] beat_data [4];
    logic        beat_we   [4];

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int lat);
        int guard;
        nbeats = 0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if ((mem_wen || mem_ren) && nbeats < 4) begin
                beat_addr[nbeats] = mem_addr;
                beat_be[nbeats]   = mem_be;
                beat_data[nbeats] = mem_data_i;
                beat_we[nbeats]   = mem_wen;
                nbeats++;
            end
        end while (!rsp_valid && lat < 10);
        rd  = rsp_rdata;
        err = rsp_err;
        if (!rsp_valid) lat = -1;
        @(negedge clk);
        check("no_double_rsp", {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic do_ereq(input logic [2:0] f3, input logic [31:0] a,
                           output logic [31:0] rd, output logic err,
                           output int lat, output logic saw_mem);
        @(negedge clk);
        e_req_valid  = 1'b1;
        e_req_we     = 1'b0;
        e_req_funct3 = f3;
        e_req_addr   = a;
        e_req_wdata  = 32'h0;
        @(posedge clk);
        #1;
        e_req_valid = 1'b0;
        lat = 0;
        saw_mem = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (e_mem_wen || e_mem_ren) saw_mem = 1'b1;
        end while (!e_rsp_valid && lat < 10);
        rd  = e_rsp_rdata;
        err = e_rsp_err;
        if (!e_rsp_valid) lat = -1;
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [1:0]  beats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
    } vec_t;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic err, logic [3:0] lat, logic [1:0] beats,
                                logic [31:0] a0, logic [3:0] be0, logic [31:0] d0,
                                logic [31:0] a1, logic [3:0] be1, logic [31:0] d1);
        vec_t v;
        v = '{we, f3, addr, wdata, rdata, err, lat, beats, a0, be0, d0, a1, be1, d1};
        return v;
    endfunction

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        saw_mem;
        int          rsp_seen;

        //                we    f3      addr           wdata          rdata          err  lat  bt  a0             be0     d0             a1             be1     d1
        vecs[0]  = mk(1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'd2, 2'd1, 32'h00000100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0);
        vecs[1]  = mk(1'b0, 3'b010, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 1'b0, 4'd2, 2'd1, 32'h00000100, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[2]  = mk(1'b1, 3'b000, 32'h00000203, 32'h000000A5, 32'h00000000, 1'b0, 4'd2, 2'd1, 32'h00000200, 4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0);
        vecs[3]  = mk(1'b0, 3'b000, 32'h00000203, 32'h00000000, 32'hFFFFFFA5, 1'b0, 4'd2, 2'd1, 32'h00000200, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[4]  = mk(1'b0, 3'b100, 32'h00000203, 32'h00000000, 32'h000000A5, 1'b0, 4'd2, 2'd1, 32'h00000200, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[5]  = mk(1'b0, 3'b000, 32'h00000200, 32'h00000000, 32'h00000044, 1'b0, 4'd2, 2'd1, 32'h00000200, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[6]  = mk(1'b1, 3'b001, 32'h00000301, 32'h00008001, 32'h00000000, 1'b0, 4'd2, 2'd1, 32'h00000300, 4'h6, 32'h00800100, 32'h0, 4'h0, 32'h0);
        vecs[7]  = mk(1'b0, 3'b001, 32'h00000301, 32'h00000000, 32'hFFFF8001, 1'b0, 4'd2, 2'd1, 32'h00000300, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[8]  = mk(1'b0, 3'b101, 32'h00000301, 32'h00000000, 32'h00008001, 1'b0, 4'd2, 2'd1, 32'h00000300, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[9]  = mk(1'b1, 3'b010, 32'h00000402, 32'hAABBCCDD, 32'h00000000, 1'b0, 4'd3, 2'd2, 32'h00000400, 4'hC, 32'hCCDD0000, 32'h00000404, 4'h3, 32'h0000AABB);
        vecs[10] = mk(1'b0, 3'b010, 32'h00000402, 32'h00000000, 32'hAABBCCDD, 1'b0, 4'd3, 2'd2, 32'h00000400, 4'hF, 32'h0,        32'h00000404, 4'hF, 32'h0);
        vecs[11] = mk(1'b0, 3'b001, 32'h00000403, 32'h00000000, 32'hFFFFBBCC, 1'b0, 4'd3, 2'd2, 32'h00000400, 4'hF, 32'h0,        32'h00000404, 4'hF, 32'h0);
        vecs[12] = mk(1'b0, 3'b011, 32'h00000100, 32'h00000000, 32'h00000000, 1'b1, 4'd1, 2'd0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[13] = mk(1'b1, 3'b100, 32'h00000100, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'd1, 2'd0, 32'h0,        4'h0, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[14] = mk(1'b0, 3'b010, 32'hFFFFFFFE, 32'h00000000, 32'hBBCC5566, 1'b0, 4'd3, 2'd2, 32'hFFFFFFFC, 4'hF, 32'h0,        32'h00000000, 4'hF, 32'h0);
        vecs[15] = mk(1'b0, 3'b101, 32'h00000102, 32'h00000000, 32'h0000DEAD, 1'b0, 4'd2, 2'd1, 32'h00000100, 4'hF, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[16] = mk(1'b0, 3'b010, 32'h00000101, 32'h00000000, 32'h00DEADBE, 1'b0, 4'd3, 2'd2, 32'h00000100, 4'hF, 32'h0,        32'h00000104, 4'hF, 32'h0);

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        e_req_valid = 1'b0; e_req_we = 1'b0; e_req_funct3 = 3'b000; e_req_addr = 32'h0; e_req_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        check("rst_mem_strb",  {30'h0, mem_wen, mem_ren}, 32'h0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_mem_be",    {28'h0, mem_be}, 32'h0);
        check("rst_mem_data",  mem_data_i, 32'h0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", {31'h0, req_ready}, 32'h1);

        // Table-driven vectors on the splitting instance
        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_latency", i), 32'(lat), {28'h0, vecs[i].lat});
            check($sformatf("v%0d_beats", i), 32'(nbeats), {30'h0, vecs[i].beats});
            if (vecs[i].beats >= 2'd1 && nbeats >= 1) begin
                check($sformatf("v%0d_b0_we", i), {31'h0, beat_we[0]}, {31'h0, vecs[i].we});
                check($sformatf("v%0d_b0_addr", i), beat_addr[0], vecs[i].a0);
                check($sformatf("v%0d_b0_be", i), {28'h0, beat_be[0]}, {28'h0, vecs[i].be0});
                if (vecs[i].we) check($sformatf("v%0d_b0_data", i), beat_data[0], vecs[i].d0);
            end
            if (vecs[i].beats == 2'd2 && nbeats >= 2) begin
                check($sformatf("v%0d_b1_we", i), {31'h0, beat_we[1]}, {31'h0, vecs[i].we});
                check($sformatf("v%0d_b1_addr", i), beat_addr[1], vecs[i].a1);
                check($sformatf("v%0d_b1_be", i), {28'h0, beat_be[1]}, {28'h0, vecs[i].be1});
                if (vecs[i].we) check($sformatf("v%0d_b1_data", i), beat_data[1], vecs[i].d1);
            end
        end
        check("illegal_store_no_write", mem[10'h040], 32'hDEADBEEF);

        // SPLIT_EN=0: crossing load rejected, aligned load still served
        do_ereq(3'b010, 32'h00000402, rd, err, lat, saw_mem);
        check("nosplit_cross_err", {31'h0, err}, 32'h1);
        check("nosplit_cross_lat", 32'(lat), 32'd1);
        check("nosplit_cross_nomem", {31'h0, saw_mem}, 32'h0);
        check("nosplit_cross_rdata", rd, 32'h0);
        do_ereq(3'b010, 32'h00000100, rd, err, lat, saw_mem);
        check("nosplit_aligned_err", {31'h0, err}, 32'h0);
        check("nosplit_aligned_lat", 32'(lat), 32'd2);
        check("nosplit_aligned_mem", {31'h0, saw_mem}, 32'h1);
        check("nosplit_aligned_rdata", rd, 32'h12345678);

        // Reset between the beats of a split store: sw 0x502, 0x11223344
        rsp_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h00000502; req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);                       // ACC0: beat 0 commits here
        check("rstx_b0_wen", {31'h0, mem_wen}, 32'h1);
        check("rstx_b0_be", {28'h0, mem_be}, 32'hC);
        @(posedge clk);
        #1;                                   // now in ACC1
        check("rstx_b1_wen_pre", {31'h0, mem_wen}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstx_wen_drop", {31'h0, mem_wen}, 32'h0);
        check("rstx_be_drop", {28'h0, mem_be}, 32'h0);
        check("rstx_addr_drop", mem_addr, 32'h0);
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rst = 1'b0;
        #1;
        check("rstx_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("rstx_no_rsp", 32'(rsp_seen), 32'd0);
        check("rstx_beat0_written", mem[10'h140], 32'h33440000);
        check("rstx_beat1_unwritten", mem[10'h141], 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits directly upstream of the single-cycle CPU's data memory and owns every byte-level concern of RISC-V loads and stores. It accepts one load/store request at a time from the execute stage. It drives the memory's word-addressed port with per-byte write enables and splits misaligned accesses that cross a word boundary into two word beats. For loads, it returns a sign- or zero-extended result.

## Interface
- SPLIT_EN, default 1: 1 = boundary-crossing accesses are split into two beats; 0 = they are rejected with rsp_err.
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE with rst low; a request is accepted on a posedge where req_valid & req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores: 000 sb, 001 sh, 010 sw.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- rsp_valid  output  1  one-cycle pulse; response complete.
- rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  output  1  qualified by rsp_valid; illegal funct3, or crossing access with SPLIT_EN=0.
- mem_wen  output  1  memory write strobe; memory commits on the following negedge.
- mem_ren  output  1  memory read strobe.
- mem_addr  output  32  byte address, always word-aligned ([1:0]=00).
- mem_be  output  4  byte enables; bank i is written when mem_wen & mem_be[i].
- mem_data_i  output  32  write data to memory.
- mem_data_o  input  32  combinational read data from memory, valid in the same cycle as mem_ren.

## Operation
- States: IDLE, ACC0, ACC1, RESP. All request fields are captured on acceptance.
- Size is 1, 2 or 4 bytes (funct3[1:0]); off = addr[1:0]. An access is crossing when off + size > 4.
- Illegal funct3 (load 011/110/111, store 011 or 1xx), or crossing with SPLIT_EN=0:
  - IDLE goes straight to RESP with rsp_err=1.
  - No mem_wen or mem_ren is issued.
- Store lanes:
  - wide64 = zero-extended wdata << 8*off.
  - be8 = (1, 3 or F per size) << off.
  - Beat 0 uses wide64[31:0] and be8[3:0]; beat 1 uses wide64[63:32] and be8[7:4].
- Load lanes:
  - lo is latched from mem_data_o in ACC0; hi is latched in ACC1, or forced to 0 when not crossing.
  - Result = ({hi,lo} >> 8*off), truncated to size.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- ACC0 drives mem_addr = {addr[31:2],00}.
  - Next state: ACC1 if crossing, else RESP.
- ACC1 drives mem_addr = {addr[31:2],00} + 4, modulo 2^32: 0xFFFFFFFC wraps to 0x00000000.
  - Next state: RESP.
- ACC0/ACC1 drive memory as follows:
  - mem_wen = we and mem_ren = !we.
  - mem_be is the beat's enable nibble for stores and 4'b1111 for loads.
- RESP asserts rsp_valid with rsp_rdata and rsp_err, then returns to IDLE unconditionally. The consumer must accept the response in that cycle.

## Timing
- Reset values: state IDLE; req_ready 0 while rst is high; rsp_valid 0, rsp_rdata 0, rsp_err 0; mem_wen 0, mem_ren 0, mem_addr 0, mem_be 0, mem_data_i 0.
- All mem_* outputs are registered or decoded from state only: they are glitch-free and stable for the whole cycle, so the memory's negedge write sees settled values.
- Latency from the acceptance edge to rsp_valid high:
  - Aligned / non-crossing: 2 cycles (ACC0, RESP).
  - Crossing: 3 cycles (ACC0, ACC1, RESP).
  - Error: 1 cycle.
- req_ready stays low from acceptance through RESP, so back-to-back requests are accepted every 3 cycles (aligned).
- Asynchronous reset in any state:
  - Returns to IDLE immediately and drops mem_wen/mem_ren within the same cycle.
  - A store split by reset between beats leaves beat 0 committed and beat 1 unwritten; this is an accepted outcome.
  - No rsp_valid is issued for the aborted request.
- rsp_valid is never high in two consecutive cycles.

## Test plan
- sw addr 0x100, data 0xDEADBEEF; then lw 0x100 -> one write beat with mem_be=1111; rsp_rdata=0xDEADBEEF; rsp_valid 2 cycles after acceptance.
- sb addr 0x203, data 0x000000A5, over a word holding 0x11223344 -> mem_be=1000, mem_data_i[31:24]=A5; then lb 0x203 -> 0xFFFFFFA5; lbu 0x203 -> 0x000000A5.
- sh 0x0301, data 0x8001; lh 0x0301 -> mem_be=0110; lh returns 0xFFFF8001; lhu returns 0x00008001.
- SPLIT_EN=1, sw 0x402, data 0xAABBCCDD:
  - Beat 0: addr 0x400, be=1100, data[31:16]=CCDD.
  - Beat 1: addr 0x404, be=0011, data[15:0]=AABB.
  - lw 0x402 -> 0xAABBCCDD after 3 cycles.
- Boundary and error cases:
  - lw 0xFFFFFFFE with SPLIT_EN=1 -> second beat addr 0x00000000.
  - funct3=011 load -> rsp_err=1 after 1 cycle, no mem_ren.
  - Same crossing access with SPLIT_EN=0 -> rsp_err=1.
- Assert rst during ACC1 of a crossing store -> mem_wen low in the same cycle; only beat 0 is written; no rsp_valid; req_ready=1 on the first cycle after rst falls.
